// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_bit_cell.sv
// Purpose: one-bit full adder cell used by the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake at this level.
module adder_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Purpose: bit-serial a + b + cin, LSB first, one bit per clock.
// Latency: WIDTH cycles from input handshake to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready low meanwhile.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    adder_bit_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (s_bit),
        .cout (c_bit)
    );

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_bit;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB on this cycle
                        sum       <= {s_bit, sum_sh[WIDTH-1:1]};
                        cout      <= c_bit;
                        ovf       <= carry ^ c_bit;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("send_in_ready", in_ready, 1);
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!out_valid && lat < 50) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        chk("result_timeout", out_valid, 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int lat;
        int nb;
        logic [W+1:0] e;
        e = model(x, y, c);
        send(x, y, c);
        wait_result(lat, nb);
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_busy_cycles"}, nb, W);
        chk({tag, "_sum"}, sum, e[W-1:0]);
        chk({tag, "_cout"}, cout, e[W]);
        chk({tag, "_ovf"}, ovf, e[W+1]);
        take();
    endtask

    initial begin
        int lat;
        int nb;
        int cyc;
        int last;
        int nacc;
        int ndone;
        bit acc_now;
        logic [W-1:0] hs;
        logic hc;
        logic hv;
        logic [W+1:0] e;
        logic [W+1:0] q[$];

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();

        // Directed arithmetic corners
        op("5a_3c", 8'h5A, 8'h3C, 1'b0);
        op("ff_01", 8'hFF, 8'h01, 1'b0);
        op("ff_00_c", 8'hFF, 8'h00, 1'b1);
        op("80_80", 8'h80, 8'h80, 1'b0);
        op("7f_01", 8'h7F, 8'h01, 1'b0);

        // Backpressure in DONE with in_valid toggling
        send(8'hA5, 8'h0F, 1'b1);
        wait_result(lat, nb);
        hs = sum;
        hc = cout;
        hv = ovf;
        e = model(8'hA5, 8'h0F, 1'b1);
        chk("bp_sum", hs, e[W-1:0]);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum_stable", sum, hs);
            chk("bp_cout_stable", cout, hc);
            chk("bp_ovf_stable", ovf, hv);
        end
        a = 8'h11;
        b = 8'h22;
        cin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_no_passthrough_busy", busy, 0);
        chk("bp_ready_after_take", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_accept_busy", busy, 1);
        wait_result(lat, nb);
        chk("bp_next_sum", sum, 8'h33);
        take();

        // Reset during RUN aborts the operation
        send(8'h55, 8'h66, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            chk("midrst_no_stale", out_valid, 0);
        end
        op("12_34", 8'h12, 8'h34, 1'b0);

        // Back-to-back random traffic, both handshakes held high
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        last = -1;
        nacc = 0;
        ndone = 0;
        while (ndone < 100 && cyc < 3000) begin
            acc_now = 1'b0;
            if (in_ready && in_valid) begin
                q.push_back(model(a, b, cin));
                if (last >= 0) chk("b2b_spacing", cyc - last, W + 2);
                last = cyc;
                acc_now = 1'b1;
                nacc++;
            end
            if (out_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("b2b_sum", sum, e[W-1:0]);
                    chk("b2b_cout", cout, e[W]);
                    chk("b2b_ovf", ovf, e[W+1]);
                end else begin
                    chk("b2b_unexpected_result", 1, 0);
                end
                ndone++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
                if (nacc >= 100) in_valid = 1'b0;
            end
        end
        chk("b2b_count", ndone, 100);
        out_ready = 1'b0;
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
